// File: rtl/day3_serial_pkg.sv
// Shared types and defaults for the bit-serial adder controller.
package day3_serial_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/day2_full_adder.sv
// Single-bit full adder cell, shared by the serial adder controller.
module day2_full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o
);

  assign sum_o  = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);

endmodule

// File: rtl/day3_serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, LSB first, one bit per clock.
// Optional subtract mode (sub_i port) is enabled by defining DAY3_SERIAL_SUB_EN.
module day3_serial_adder_ctrl
  import day3_serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  input  logic             cin_i,
`ifdef DAY3_SERIAL_SUB_EN
  input  logic             sub_i,
`endif
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             busy_o
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, b_reg, sum_reg;
  logic             carry_reg, cout_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic             fa_sum, fa_cout;
  logic [WIDTH-1:0] b_capture;
  logic             carry_capture;

`ifdef DAY3_SERIAL_SUB_EN
  // Subtract as A + ~B + 1; the caller's carry-in is ignored in that mode.
  assign b_capture     = sub_i ? ~op_b_i : op_b_i;
  assign carry_capture = sub_i ? 1'b1 : cin_i;
`else
  assign b_capture     = op_b_i;
  assign carry_capture = cin_i;
`endif

  day2_full_adder u_fa (
    .a_i    (a_reg[0]),
    .b_i    (b_reg[0]),
    .cin_i  (carry_reg),
    .sum_o  (fa_sum),
    .cout_o (fa_cout)
  );

  always_comb begin
    state_next  = state_reg;
    in_ready_o  = 1'b0;
    busy_o      = 1'b0;
    res_valid_o = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready_o = 1'b1;
        if (in_valid_i) state_next = RUN;
      end
      RUN: begin
        busy_o = 1'b1;
        if (cnt_reg == LAST_BIT) state_next = DONE;
      end
      DONE: begin
        res_valid_o = 1'b1;
        if (res_ready_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (in_valid_i) begin
            a_reg     <= op_a_i;
            b_reg     <= b_capture;
            carry_reg <= carry_capture;
            cnt_reg   <= '0;
          end
        end
        RUN: begin
          // Sum bits enter at the MSB so the word is aligned after WIDTH shifts.
          sum_reg   <= {fa_sum, sum_reg[WIDTH-1:1]};
          a_reg     <= {1'b0, a_reg[WIDTH-1:1]};
          b_reg     <= {1'b0, b_reg[WIDTH-1:1]};
          carry_reg <= fa_cout;
          if (cnt_reg == LAST_BIT) begin
            cout_reg <= fa_cout;
            cnt_reg  <= '0;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign sum_o  = sum_reg;
  assign cout_o = cout_reg;

endmodule

// File: tb/tb_day3_serial_adder_ctrl.sv
// Directed bench for day3_serial_adder_ctrl: WIDTH=8 scenarios plus an exhaustive WIDTH=4 sweep.
module tb_day3_serial_adder_ctrl;

  logic       clk;
  logic       rst_n;

  logic       in_valid8, in_ready8, res_valid8, res_ready8, cin8, cout8, busy8, sub8;
  logic [7:0] op_a8, op_b8, sum8;

  logic       in_valid4, in_ready4, res_valid4, res_ready4, cin4, cout4, busy4;
  logic [3:0] op_a4, op_b4, sum4;
`ifdef DAY3_SERIAL_SUB_EN
  logic       sub4;
`endif

  int pass_cnt  = 0;
  int check_cnt = 0;

  day3_serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid8),
    .in_ready_o  (in_ready8),
    .op_a_i      (op_a8),
    .op_b_i      (op_b8),
    .cin_i       (cin8),
`ifdef DAY3_SERIAL_SUB_EN
    .sub_i       (sub8),
`endif
    .res_valid_o (res_valid8),
    .res_ready_i (res_ready8),
    .sum_o       (sum8),
    .cout_o      (cout8),
    .busy_o      (busy8)
  );

  day3_serial_adder_ctrl #(.WIDTH(4)) dut4 (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid4),
    .in_ready_o  (in_ready4),
    .op_a_i      (op_a4),
    .op_b_i      (op_b4),
    .cin_i       (cin4),
`ifdef DAY3_SERIAL_SUB_EN
    .sub_i       (sub4),
`endif
    .res_valid_o (res_valid4),
    .res_ready_i (res_ready4),
    .sum_o       (sum4),
    .cout_o      (cout4),
    .busy_o      (busy4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Launch one WIDTH=8 operation and wait (bounded) for res_valid; leaves the DUT in DONE.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c, input logic s,
                      output int lat, output int busy_n);
    int guard;
    guard = 0;
    while (!in_ready8 && guard < 40) begin
      @(posedge clk); #1;
      guard++;
    end
    op_a8 = a; op_b8 = b; cin8 = c; sub8 = s;
    in_valid8 = 1'b1;
    res_ready8 = 1'b0;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    lat = 0;
    busy_n = 0;
    while (!res_valid8 && lat < 40) begin
      if (busy8) busy_n++;
      @(posedge clk); #1;
      lat++;
    end
    $display("op8 a=%h b=%h cin=%0d sub=%0d -> sum=%h cout=%0d lat=%0d busy=%0d",
             a, b, c, s, sum8, cout8, lat, busy_n);
  endtask

  task automatic release8();
    res_ready8 = 1'b1;
    @(posedge clk); #1;
    res_ready8 = 1'b0;
    check_cnt++;
    if (res_valid8 !== 1'b0 || in_ready8 !== 1'b1)
      $display("FAIL release8: res_valid=%b in_ready=%b, required 0/1", res_valid8, in_ready8);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_cnt++;
    if ({in_ready8, res_valid8, busy8, cout8, sum8} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00})
      $display("FAIL reset_state: rdy=%b vld=%b busy=%b cout=%b sum=%h, required 1 0 0 0 00",
               in_ready8, res_valid8, busy8, cout8, sum8);
    else pass_cnt++;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_cnt++;
    if (in_ready8 !== 1'b1 || res_valid8 !== 1'b0 || busy8 !== 1'b0)
      $display("FAIL idle_hold: rdy=%b vld=%b busy=%b, required 1 0 0", in_ready8, res_valid8, busy8);
    else pass_cnt++;
    $display("reset done");
  endtask

  task automatic test_add_vectors();
    logic [7:0] va [3];
    logic [7:0] vb [3];
    logic       vc [3];
    logic [7:0] vs [3];
    logic       vo [3];
    int lat, busy_n;
    va = '{8'h0F, 8'hFF, 8'hAA};
    vb = '{8'h01, 8'h01, 8'h55};
    vc = '{1'b0, 1'b0, 1'b1};
    vs = '{8'h10, 8'h00, 8'h00};
    vo = '{1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 3; i++) begin
      run8(va[i], vb[i], vc[i], 1'b0, lat, busy_n);
      check_cnt++;
      if (lat !== 8) $display("FAIL latency_%0d: got %0d edges, required 8", i, lat);
      else pass_cnt++;
      check_cnt++;
      if (busy_n !== 8) $display("FAIL busy_cycles_%0d: got %0d, required 8", i, busy_n);
      else pass_cnt++;
      check_cnt++;
      if (sum8 !== vs[i] || cout8 !== vo[i])
        $display("FAIL add_%0d: sum=%h cout=%b, required %h %b", i, sum8, cout8, vs[i], vo[i]);
      else pass_cnt++;
      release8();
    end
  endtask

  task automatic test_backpressure();
    int lat, busy_n;
    run8(8'h3C, 8'h0F, 1'b0, 1'b0, lat, busy_n);
    for (int i = 0; i < 5; i++) begin
      in_valid8 = (i % 2 == 0);
      op_a8 = 8'hFF; op_b8 = 8'hFF; cin8 = 1'b1;
      @(posedge clk); #1;
      check_cnt++;
      if (sum8 !== 8'h4B || cout8 !== 1'b0 || in_ready8 !== 1'b0 || res_valid8 !== 1'b1)
        $display("FAIL backpressure_%0d: sum=%h cout=%b rdy=%b vld=%b, required 4b 0 0 1",
                 i, sum8, cout8, in_ready8, res_valid8);
      else pass_cnt++;
    end
    in_valid8 = 1'b0;
    release8();
    check_cnt++;
    if (sum8 !== 8'h4B) $display("FAIL sum_retained: sum=%h, required 4b", sum8);
    else pass_cnt++;
    run8(8'h01, 8'h02, 1'b0, 1'b0, lat, busy_n);
    check_cnt++;
    if (sum8 !== 8'h03 || cout8 !== 1'b0 || lat !== 8)
      $display("FAIL after_backpressure: sum=%h cout=%b lat=%0d, required 03 0 8", sum8, cout8, lat);
    else pass_cnt++;
    release8();
  endtask

  task automatic test_reset_mid_run();
    int lat, busy_n;
    op_a8 = 8'hFF; op_b8 = 8'hFF; cin8 = 1'b0; sub8 = 1'b0;
    in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_cnt++;
    if ({in_ready8, res_valid8, busy8, cout8, sum8} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00})
      $display("FAIL reset_mid_run: rdy=%b vld=%b busy=%b cout=%b sum=%h, required 1 0 0 0 00",
               in_ready8, res_valid8, busy8, cout8, sum8);
    else pass_cnt++;
    run8(8'h12, 8'h34, 1'b0, 1'b0, lat, busy_n);
    check_cnt++;
    if (sum8 !== 8'h46 || cout8 !== 1'b0 || lat !== 8)
      $display("FAIL fresh_after_reset: sum=%h cout=%b lat=%0d, required 46 0 8", sum8, cout8, lat);
    else pass_cnt++;
    release8();
  endtask

  task automatic test_sweep_w4();
    int lat, errs;
    logic [4:0] ref_sum;
    errs = 0;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int c = 0; c < 2; c++) begin
          op_a4 = 4'(a); op_b4 = 4'(b); cin4 = 1'(c);
          in_valid4 = 1'b1;
          @(posedge clk); #1;
          in_valid4 = 1'b0;
          lat = 0;
          while (!res_valid4 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
          end
          ref_sum = 5'(a) + 5'(b) + 5'(c);
          check_cnt++;
          if (sum4 !== ref_sum[3:0]) begin
            $display("FAIL sweep_sum a=%h b=%h c=%0d: sum=%h, required %h", a, b, c, sum4, ref_sum[3:0]);
            errs++;
          end else pass_cnt++;
          check_cnt++;
          if (cout4 !== ref_sum[4] || lat !== 4) begin
            $display("FAIL sweep_cout a=%h b=%h c=%0d: cout=%b lat=%0d, required %b 4",
                     a, b, c, cout4, lat, ref_sum[4]);
            errs++;
          end else pass_cnt++;
          res_ready4 = 1'b1;
          @(posedge clk); #1;
          res_ready4 = 1'b0;
        end
      end
    end
    $display("sweep w4: 512 operations, %0d mismatching checks", errs);
  endtask

`ifdef DAY3_SERIAL_SUB_EN
  task automatic test_subtract();
    int lat, busy_n;
    run8(8'h05, 8'h07, 1'b1, 1'b1, lat, busy_n);
    check_cnt++;
    if (sum8 !== 8'hFE || cout8 !== 1'b0)
      $display("FAIL sub_borrow: sum=%h cout=%b, required fe 0", sum8, cout8);
    else pass_cnt++;
    release8();
    run8(8'h07, 8'h05, 1'b0, 1'b1, lat, busy_n);
    check_cnt++;
    if (sum8 !== 8'h02 || cout8 !== 1'b1)
      $display("FAIL sub_no_borrow: sum=%h cout=%b, required 02 1", sum8, cout8);
    else pass_cnt++;
    release8();
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    in_valid8 = 1'b0; res_ready8 = 1'b0; op_a8 = '0; op_b8 = '0; cin8 = 1'b0; sub8 = 1'b0;
    in_valid4 = 1'b0; res_ready4 = 1'b0; op_a4 = '0; op_b4 = '0; cin4 = 1'b0;
`ifdef DAY3_SERIAL_SUB_EN
    sub4 = 1'b0;
`endif
    test_reset();
    test_add_vectors();
    test_backpressure();
    test_reset_mid_run();
    test_sweep_w4();
`ifdef DAY3_SERIAL_SUB_EN
    test_subtract();
`endif
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
